pattern_detect: RTL and testbench
=================================

# pattern_detect

Parametrised serial pattern detector, successor to the fixed 11011 detector. Pattern, length (1..MAX_LEN) and overlap mode are runtime-programmable. Sits on a serial bit stream with a per-bit valid qualifier. Emits a registered one-cycle match pulse and, optionally, a saturating match count.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits (≥2).
- CNT_W, default 16: match counter width.
- LEN_W, derived: $clog2(MAX_LEN+1); width of cfg_len.
- clk  in  1  sole clock; rising edge active.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  load cfg_pattern, cfg_len, cfg_overlap; clears history.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- din_valid  in  1  din is a new stream bit this cycle.
- din  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  one-cycle pulse; completing bit matched.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- Configuration registers: pat_q, len_q, ovl_q. Written only on cfg_load.
- cfg_len of 0 means disabled: no matches are reported. cfg_len greater than MAX_LEN is clamped to MAX_LEN.
- History: hist_q is a MAX_LEN-bit shift register. On each accepted bit: hist_q <= {hist_q[MAX_LEN-2:0], din}.
- Fill counter fill_q (LEN_W bits) counts accepted bits. It saturates at len_q.
- Match condition, evaluated on an accepted bit:
  - len_q ≠ 0,
  - the fill count including this bit is ≥ len_q,
  - the low len_q bits of the new history equal pat_q[len_q-1:0].
- FSM states (fill-driven):
  - IDLE: len_q = 0.
  - FILL: fill < len_q.
  - ARMED: fill = len_q.
- Transitions:
  - cfg_load: go to IDLE if the new length is 0, else FILL, with fill = 0.
  - FILL → ARMED when fill reaches len_q.
  - On a match with ovl_q = 0: fill_q <= 0 and hist_q <= 0, returning to FILL. The matched bits are not reused.
  - On a match with ovl_q = 1: stay ARMED.
- cfg_load and din_valid in the same cycle: cfg_load wins. The din bit is discarded, and no match is evaluated against either configuration.
- match_cnt:
  - Increments by 1 on each match and holds at all-ones.
  - cnt_clr and a match in the same cycle: clear wins, and match_cnt = 0.
  - cfg_load does not clear match_cnt.

## Timing
- Reset values:
  - match = 0, match_cnt = 0.
  - hist_q = 0, fill_q = 0, pat_q = 0, len_q = 0, ovl_q = 1. The block is disabled until the first cfg_load.
- Latency: match is registered. It is high in the cycle after the clk edge that accepts the completing bit, for exactly one cycle.
- match_cnt updates on the same edge that raises match.
- New configuration takes effect from the first din_valid after the cfg_load edge.
- din_valid low: all state holds and match = 0.
- Back-to-back bits with din_valid high every cycle are fully supported. Matches on consecutive bits are possible, e.g. pattern 11 in overlap mode on 111 gives two adjacent pulses.
- Reset asserted mid-stream: all state returns to the reset values immediately and asynchronously. Any in-flight match pulse is lost.

## Configuration
- MATCH_CNT_EN defined: match counter, cnt_clr and saturation logic are present.
- MATCH_CNT_EN undefined:
  - Counter logic is removed.
  - match_cnt is tied to 0.
  - cnt_clr is ignored.
  - The port list is unchanged.

## Structure
- Package pattern_detect_pkg holds:
  - the state enum {IDLE, FILL, ARMED},
  - the LEN_W derivation function,
  - a clamp-length function.
- Sub-module pattern_detect_cnt holds the saturating CNT_W counter with clear priority. It is instantiated only under MATCH_CNT_EN.
- The top level holds the configuration registers, shift register, fill counter, comparator and FSM.

## Test plan
- Overlap. Config len=5, pat=5'b11011, overlap=1. Stream 1,1,0,1,1,0,1,1 → match after bits 5 and 8. match_cnt = 2.
- Non-overlap. Same stream with overlap=0 → match after bit 5 only. match_cnt = 1.
- Gapped valid. len=3, pat=3'b101. Stream 1,0,1 with din_valid low for 2 cycles between bits → one match, one cycle after the third accepted bit. No pulse during the gaps.
- Collision and disable cases:
  - cfg_load in the same cycle as a completing bit → no match.
  - The next 5 bits 11011 with the new config → a match.
  - len=0 with any stream → no match.
- Counter. Force CNT_W=4 and run 20 overlapping matches → match_cnt saturates at 15. cnt_clr together with a match → 0.
- Async reset asserted between clk edges mid-pattern → match and match_cnt are 0 immediately. After release, the same pattern does not match until cfg_load.

Source files
------------

// File: rtl/pattern_detect_pkg.sv
// Shared types and width helpers for the programmable serial pattern detector.
package pattern_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_e;

  // Width of the length field: it must hold every value from 0 to max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_detect_cnt.sv
// Saturating match counter; a synchronous clear takes priority over an increment.
module pattern_detect_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pattern_detect.sv
// Runtime-programmable serial pattern detector with overlap control.
// Define MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module pattern_detect
  import pattern_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               fill_full;
  logic               pat_eq;

  // The oldest history bit falls off the end of the shift and is never compared.
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[MAX_LEN-1];

  assign hist_shift = {hist_q[MAX_LEN-2:0], din};

  // One extra bit so the increment cannot wrap when len_q sits at the top of its range.
  assign fill_inc  = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_full = fill_inc >= {1'b0, len_q};

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign pat_eq = ((hist_shift ^ pat_q) & len_mask) == '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;

    if (cfg_load) begin
      // A bit arriving alongside cfg_load is dropped and never evaluated.
      pat_d   = cfg_pattern;
      len_d   = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (len_d == '0) ? IDLE : FILL;
    end else if (din_valid) begin
      unique case (state_q)
        IDLE: ;
        FILL, ARMED: begin
          hist_d = hist_shift;
          fill_d = fill_full ? len_q : fill_inc[LEN_W-1:0];
          if (fill_full) begin
            state_d = ARMED;
            if (pat_eq) begin
              match_d = 1'b1;
              if (!ovl_q) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge values, whatever the statement order.
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

`ifdef MATCH_CNT_EN
  pattern_detect_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr_i(cnt_clr),
    .inc_i(match_d),
    .cnt_o(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detect.sv
// Self-checking bench for pattern_detect: directed scenarios plus a randomized run against a queue-based model.
module tb_pattern_detect;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = 15;
`ifdef MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;

  pattern_detect #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .din_valid  (din_valid),
    .din        (din),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the bits accepted since the last configuration (or last non-overlapping match).
  bit         m_q[$];
  int         m_len;
  logic [7:0] m_pat;
  bit         m_ovl;
  int         m_cnt;
  bit         e_match;
  logic [CNT_W-1:0] e_cnt;

  task automatic m_reset();
    m_q.delete();
    m_len = 0;
    m_pat = '0;
    m_ovl = 1'b1;
    m_cnt = 0;
    e_match = 1'b0;
    e_cnt = '0;
  endtask

  task automatic m_step(input bit ld, input logic [7:0] pat, input int len, input bit ovl,
                        input bit v, input bit d, input bit clr);
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (len > MAX_LEN) ? MAX_LEN : len;
      m_ovl = ovl;
      m_q.delete();
    end else if (v && m_len > 0) begin
      m_q.push_back(d);
      if (m_q.size() > m_len) void'(m_q.pop_front());
      if (m_q.size() == m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (m_q[k] != m_pat[m_len-1-k]) hit = 1'b0;
        if (hit && !m_ovl) m_q.delete();
      end
    end
    if (clr) m_cnt = 0;
    else if (hit && m_cnt < CNT_MAX) m_cnt++;
    e_match = hit;
    e_cnt = CNT_EN ? CNT_W'(m_cnt) : '0;
  endtask

  // Apply one cycle of inputs, advance the model, and leave outputs settled 1 ns after the edge.
  task automatic cyc(input bit ld, input logic [7:0] pat, input int len, input bit ovl,
                     input bit v, input bit d, input bit clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    din_valid = v; din = d; cnt_clr = clr;
    m_step(ld, pat, len, ovl, v, d, clr);
    @(posedge clk);
    #1;
    cfg_load = 1'b0; din_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send_bit(input bit d);
    cyc(1'b0, 8'h00, 0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (match !== 1'b0 || match_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_values: match=%b cnt=%0d, expected match=0 cnt=0", match, match_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      n_cmp++;
      if (match !== 1'b0) begin
        n_bad++;
        $display("FAIL disabled_after_reset: match=%b, expected 0", match);
      end
    end
  endtask

  task automatic run_stream(input string name, input bit ovl, output int pulses);
    bit s[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
    pulses = 0;
    cyc(1'b1, 8'b11011, 5, ovl, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_bit(s[i]);
      pulses += int'(match);
      n_cmp++;
      if (match !== e_match || match_cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL %s bit%0d: match=%b cnt=%0d, expected match=%b cnt=%0d",
                 name, i + 1, match, match_cnt, e_match, e_cnt);
      end
    end
  endtask

  task automatic test_overlap();
    int p;
    run_stream("overlap", 1'b1, p);
    n_cmp++;
    if (p != 2 || match_cnt !== (CNT_EN ? 4'd2 : 4'd0)) begin
      n_bad++;
      $display("FAIL overlap_total: pulses=%0d cnt=%0d, expected pulses=2 cnt=%0d", p, match_cnt, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_non_overlap();
    int p;
    run_stream("non_overlap", 1'b0, p);
    n_cmp++;
    if (p != 1 || match_cnt !== (CNT_EN ? 4'd1 : 4'd0)) begin
      n_bad++;
      $display("FAIL non_overlap_total: pulses=%0d cnt=%0d, expected pulses=1 cnt=%0d", p, match_cnt, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_gapped();
    bit s[3] = '{1, 0, 1};
    int p = 0;
    cyc(1'b1, 8'b101, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_bit(s[i]);
      p += int'(match);
      n_cmp++;
      if (match !== e_match) begin
        n_bad++;
        $display("FAIL gapped bit%0d: match=%b, expected %b", i + 1, match, e_match);
      end
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          cyc(1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b0);
          n_cmp++;
          if (match !== 1'b0) begin
            n_bad++;
            $display("FAIL gapped_idle: match=%b during gap, expected 0", match);
          end
        end
      end
    end
    n_cmp++;
    if (p != 1) begin
      n_bad++;
      $display("FAIL gapped_total: pulses=%0d, expected 1", p);
    end
  endtask

  task automatic test_collision();
    bit s[5] = '{1, 1, 0, 1, 1};
    cyc(1'b1, 8'b11011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(s[i]);
    cyc(1'b1, 8'b11011, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (match !== 1'b0) begin
      n_bad++;
      $display("FAIL collision: match=%b, expected 0", match);
    end
    for (int i = 0; i < 5; i++) send_bit(s[i]);
    n_cmp++;
    if (match !== 1'b1) begin
      n_bad++;
      $display("FAIL collision_reload: match=%b, expected 1", match);
    end
  endtask

  task automatic test_disabled();
    cyc(1'b1, 8'hFF, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_bit(1'($urandom));
      n_cmp++;
      if (match !== 1'b0) begin
        n_bad++;
        $display("FAIL len_zero: match=%b, expected 0", match);
      end
    end
  endtask

  task automatic test_saturate();
    cyc(1'b1, 8'b11, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) send_bit(1'b1);
    n_cmp++;
    if (match_cnt !== (CNT_EN ? 4'd15 : 4'd0)) begin
      n_bad++;
      $display("FAIL saturate: cnt=%0d, expected %0d", match_cnt, CNT_EN ? 15 : 0);
    end
    cyc(1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (match !== 1'b1 || match_cnt !== '0) begin
      n_bad++;
      $display("FAIL clr_vs_match: match=%b cnt=%0d, expected match=1 cnt=0", match, match_cnt);
    end
  endtask

  task automatic test_random();
    bit ld, v, d, clr, ovl;
    logic [7:0] pat;
    int len;
    for (int i = 0; i < 800; i++) begin
      ld  = ($urandom_range(0, 39) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 4);
      ovl = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      cyc(ld, pat, len, ovl, v, d, clr);
      n_cmp++;
      if (match !== e_match || match_cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL random cyc%0d: match=%b cnt=%0d, expected match=%b cnt=%0d",
                 i, match, match_cnt, e_match, e_cnt);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit s[5] = '{1, 1, 0, 1, 1};
    cyc(1'b1, 8'b11011, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
    n_cmp++;
    if (match !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_pulse: match=%b, expected 1", match);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (match !== 1'b0 || match_cnt !== '0) begin
      n_bad++;
      $display("FAIL async_reset: match=%b cnt=%0d, expected match=0 cnt=0", match, match_cnt);
    end
    #3;
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      send_bit(s[i]);
      n_cmp++;
      if (match !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_disabled: match=%b, expected 0", match);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gapped();
    test_collision();
    test_disabled();
    test_saturate();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
